// File: rtl/coverfloat_flag_tally_pkg.sv
// Shared types and constants for the coverfloat flag tally block.
// The rounding-mode field is carried only when COVERFLOAT_RM_HIST_EN is defined.
package coverfloat_flag_tally_pkg;

  localparam int N_OP_CLASS = 16;
  localparam int N_FLAGS    = 5;
  localparam int N_RM       = 5;
  localparam int MAJOR_W    = 28;

  // SoftFloat exception flag masks
  localparam logic [N_FLAGS-1:0] FLAG_INEXACT   = 5'h01;
  localparam logic [N_FLAGS-1:0] FLAG_UNDERFLOW = 5'h02;
  localparam logic [N_FLAGS-1:0] FLAG_OVERFLOW  = 5'h04;
  localparam logic [N_FLAGS-1:0] FLAG_INFINITE  = 5'h08;
  localparam logic [N_FLAGS-1:0] FLAG_INVALID   = 5'h10;

  localparam logic [MAJOR_W-1:0] OP_ADD   = 28'h1;
  localparam logic [MAJOR_W-1:0] OP_SUB   = 28'h2;
  localparam logic [MAJOR_W-1:0] OP_MUL   = 28'h3;
  localparam logic [MAJOR_W-1:0] OP_DIV   = 28'h4;
  localparam logic [MAJOR_W-1:0] OP_FMA   = 28'h5;
  localparam logic [MAJOR_W-1:0] OP_SQRT  = 28'h6;
  localparam logic [MAJOR_W-1:0] OP_FIRST = 28'h1;
  localparam logic [MAJOR_W-1:0] OP_LAST  = 28'h10;

  typedef enum logic [2:0] {
    RM_NEAR_EVEN    = 3'd0,
    RM_MIN_MAG      = 3'd1,
    RM_MIN          = 3'd2,
    RM_MAX          = 3'd3,
    RM_NEAR_MAX_MAG = 3'd4
  } rm_e;

  typedef enum logic [3:0] {
    FMT_F16  = 4'd0,
    FMT_BF16 = 4'd1,
    FMT_F32  = 4'd2,
    FMT_F64  = 4'd3,
    FMT_F128 = 4'd4
  } fmt_e;

  typedef struct packed {
    logic [MAJOR_W-1:0] major;
`ifdef COVERFLOAT_RM_HIST_EN
    logic [7:0]         rm;
`endif
    logic [N_FLAGS-1:0] flags;
  } fifo_entry_t;

  function automatic logic is_counted(input logic [MAJOR_W-1:0] major);
    return (major >= OP_FIRST) && (major <= OP_LAST);
  endfunction

endpackage

// File: rtl/coverfloat_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requesting lane at or after
// the priority pointer; the pointer moves past the winner on every grant.
module coverfloat_rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic [PW-1:0]     grant_idx
);

  logic [PW-1:0] ptr;
  logic          found;

  // NOTE: every output of this block is given a default first so no path
  // through the loops can leave a value held, which would infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    // Lanes at or above the pointer win first, then wrap to the low lanes.
    for (int c = 0; c < NUM_CH; c++) begin
      if (!found && en && req[c] && (PW'(c) >= ptr)) begin
        found     = 1'b1;
        grant[c]  = 1'b1;
        grant_idx = PW'(c);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!found && en && req[c] && (PW'(c) < ptr)) begin
        found     = 1'b1;
        grant[c]  = 1'b1;
        grant_idx = PW'(c);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (grant_idx == PW'(NUM_CH - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

endmodule

// File: rtl/coverfloat_flag_tally.sv
// Multi-lane FP result record tally: round-robin intake, small FIFO, saturating
// per-class counters with request/response readout. Option: COVERFLOAT_RM_HIST_EN.
module coverfloat_flag_tally
  import coverfloat_flag_tally_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     in_valid,
  output logic [NUM_CH-1:0]     in_ready,
  input  logic [32*NUM_CH-1:0]  in_op,
  input  logic [8*NUM_CH-1:0]   in_rm,
  input  logic [8*NUM_CH-1:0]   in_flags,
  input  logic                  clr,
  input  logic                  rd_req,
  input  logic [3:0]            rd_idx,
  output logic                  rd_resp_valid,
  output logic [CNT_W-1:0]      rd_total,
  output logic [5*CNT_W-1:0]    rd_flag_cnt,
`ifdef COVERFLOAT_RM_HIST_EN
  output logic [5*CNT_W-1:0]    rd_rm_cnt,
`endif
  output logic [CNT_W-1:0]      drop_cnt,
  output logic                  busy
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = $clog2(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [31:0]   op_lane    [NUM_CH];
  logic [7:0]    rm_lane    [NUM_CH];
  logic [7:0]    flags_lane [NUM_CH];
  logic [PW-1:0] grant_idx;
  logic          full, empty, accept, pop;

  for (genvar l = 0; l < NUM_CH; l++) begin : g_lane
    assign op_lane[l]    = in_op[l*32 +: 32];
    assign rm_lane[l]    = in_rm[l*8 +: 8];
    assign flags_lane[l] = in_flags[l*8 +: 8];
  end

  coverfloat_rr_arbiter #(.NUM_CH(NUM_CH), .PW(PW)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_valid),
    .en        (!full && !reset),
    .grant     (in_ready),
    .grant_idx (grant_idx)
  );

  assign accept = |in_ready;

  logic [31:0] sel_op;
  logic [7:0]  sel_rm, sel_flags;
  fifo_entry_t push_entry;

  assign sel_op    = op_lane[grant_idx];
  assign sel_rm    = rm_lane[grant_idx];
  assign sel_flags = flags_lane[grant_idx];

  always_comb begin
    push_entry       = '0;
    push_entry.major = sel_op[31:4];
`ifdef COVERFLOAT_RM_HIST_EN
    push_entry.rm    = sel_rm;
`endif
    push_entry.flags = sel_flags[N_FLAGS-1:0];
  end

  // Op variant and flag bits 7:5 never affect any counter.
`ifdef COVERFLOAT_RM_HIST_EN
  logic unused_bits;
  assign unused_bits = ^{sel_op[3:0], sel_flags[7:5]};
`else
  logic unused_bits;
  assign unused_bits = ^{sel_op[3:0], sel_flags[7:5], sel_rm};
`endif

  // FIFO: pointers carry one extra wrap bit to tell full from empty.
  fifo_entry_t mem [DEPTH];
  fifo_entry_t head;
  logic [AW:0] wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty;
  assign busy  = !empty;
  assign head  = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset; an entry is only read after the
  // write pointer has passed it, so its power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Counter array
  logic [CNT_W-1:0]              cnt_total [N_OP_CLASS];
  logic [N_FLAGS-1:0][CNT_W-1:0] cnt_flag  [N_OP_CLASS];
`ifdef COVERFLOAT_RM_HIST_EN
  logic [N_RM-1:0][CNT_W-1:0]    cnt_rm    [N_OP_CLASS];
`endif
  logic [3:0] head_cls;

  assign head_cls = head.major[3:0] - 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
      for (int c = 0; c < N_OP_CLASS; c++) begin
        cnt_total[c] <= '0;
        cnt_flag[c]  <= '0;
`ifdef COVERFLOAT_RM_HIST_EN
        cnt_rm[c]    <= '0;
`endif
      end
    end else if (clr) begin
      // A record popped under clr is discarded along with the old counts.
      drop_cnt <= '0;
      for (int c = 0; c < N_OP_CLASS; c++) begin
        cnt_total[c] <= '0;
        cnt_flag[c]  <= '0;
`ifdef COVERFLOAT_RM_HIST_EN
        cnt_rm[c]    <= '0;
`endif
      end
    end else if (pop) begin
      if (is_counted(head.major)) begin
        cnt_total[head_cls] <= sat_inc(cnt_total[head_cls]);
        for (int k = 0; k < N_FLAGS; k++) begin
          if (head.flags[k]) cnt_flag[head_cls][k] <= sat_inc(cnt_flag[head_cls][k]);
        end
`ifdef COVERFLOAT_RM_HIST_EN
        if (head.rm < 8'(N_RM))
          cnt_rm[head_cls][head.rm[2:0]] <= sat_inc(cnt_rm[head_cls][head.rm[2:0]]);
`endif
      end else begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  // Readout captures counters before this edge's update or clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_resp_valid <= 1'b0;
      rd_total      <= '0;
      rd_flag_cnt   <= '0;
`ifdef COVERFLOAT_RM_HIST_EN
      rd_rm_cnt     <= '0;
`endif
    end else begin
      rd_resp_valid <= rd_req;
      if (rd_req) begin
        rd_total    <= cnt_total[rd_idx];
        rd_flag_cnt <= cnt_flag[rd_idx];
`ifdef COVERFLOAT_RM_HIST_EN
        rd_rm_cnt   <= cnt_rm[rd_idx];
`endif
      end
    end
  end

endmodule
